// File: rtl/gdo.sv
// Fixed-point helper package for the gradient/weight datapath.
// Qm.n format: gdo_data_size total bits, gdo_size fraction bits.
// Also holds the weight-update FSM state type and the gradient clip
// bound used when WEIGHT_UPDATE_GRAD_CLIP_EN is defined.
package gdo;
  localparam int gdo_data_size = 16;
  localparam int gdo_size      = 8;

  typedef logic signed [gdo_data_size-1:0]   gdo_t;
  typedef logic signed [2*gdo_data_size-1:0] gdo_wide_t;

  localparam gdo_wide_t GDO_MAX = gdo_wide_t'(2**(gdo_data_size-1) - 1);
  localparam gdo_wide_t GDO_MIN = -gdo_wide_t'(2**(gdo_data_size-1));

  // Gradient clamp bound: 1.0 in Q format.
  localparam gdo_t GRAD_CLIP     = gdo_t'(2**gdo_size);
  localparam gdo_t GRAD_CLIP_NEG = -GRAD_CLIP;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } wu_state_e;

  // Full-precision product rescaled to Q format; left wide so the caller
  // saturates once after the subtract instead of twice.
  function automatic gdo_wide_t gdo_mult(input gdo_t a, input gdo_t b);
    gdo_wide_t p;
    p = gdo_wide_t'(a) * gdo_wide_t'(b);
    return p >>> gdo_size;
  endfunction

  function automatic gdo_t gdo_sat(input gdo_wide_t v);
    gdo_t r;
    if (v > GDO_MAX)      r = gdo_t'(GDO_MAX);
    else if (v < GDO_MIN) r = gdo_t'(GDO_MIN);
    else                  r = gdo_t'(v);
    return r;
  endfunction

  function automatic gdo_t gdo_add(input gdo_t a, input gdo_t b);
    return gdo_sat(gdo_wide_t'(a) + gdo_wide_t'(b));
  endfunction

  // a - b with b already wide (e.g. a raw gdo_mult result).
  function automatic gdo_t gdo_sat_sub(input gdo_t a, input gdo_wide_t b);
    return gdo_sat(gdo_wide_t'(a) - b);
  endfunction
endpackage

// File: rtl/weight_update_stream_row_updater.sv
// weight_row_updater: combinational SGD step for one weight row.
// Per lane: w_new = sat(w - lr*g). With WEIGHT_UPDATE_GRAD_CLIP_EN the
// gradient is first clamped to +/-GRAD_CLIP and clip_o flags any clamp.
module weight_row_updater
  import gdo::*;
#(
  parameter int data_size = 16,
  parameter int size      = 3
) (
  input  logic [size*data_size-1:0] w_row_i,
  input  logic [size*data_size-1:0] g_row_i,
  input  logic [data_size-1:0]      lr_i,
  output logic [size*data_size-1:0] w_row_o
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
  ,
  output logic                      clip_o
`endif
);

`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
  logic [size-1:0] clip_lane;
  assign clip_o = |clip_lane;
`endif

  for (genvar i = 0; i < size; i++) begin : g_lane
    gdo_t w_cur;
    gdo_t g_raw;
    gdo_t g_use;

    // Element 0 lives in the most significant slot of the row.
    assign w_cur = gdo_t'(w_row_i[(size-i)*data_size-1 -: data_size]);
    assign g_raw = gdo_t'(g_row_i[(size-i)*data_size-1 -: data_size]);

`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
    logic hit;
    // Clamp the gradient so one spiky element cannot produce a huge step.
    always_comb begin
      g_use = g_raw;
      hit   = 1'b0;
      if (g_raw > GRAD_CLIP) begin
        g_use = GRAD_CLIP;
        hit   = 1'b1;
      end else if (g_raw < GRAD_CLIP_NEG) begin
        g_use = GRAD_CLIP_NEG;
        hit   = 1'b1;
      end
    end
    assign clip_lane[i] = hit;
`else
    assign g_use = g_raw;
`endif

    assign w_row_o[(size-i)*data_size-1 -: data_size] =
      gdo_sat_sub(w_cur, gdo_mult(gdo_t'(lr_i), g_use));
  end

endmodule

// File: rtl/weight_update_stream.sv
// weight_update_stream: reader end of the dC/dW gradient stream.
// Collects size rows of gradient for one layer, then applies
// w <- sat(w - lr*g) one row per cycle into the per-layer weight bank.
// Also offers a load port (IDLE only) and a 1-cycle registered read port.
// Optional: WEIGHT_UPDATE_GRAD_CLIP_EN adds gradient clamping and clip_hit.
module weight_update_stream
  import gdo::*;
#(
  parameter int data_size      = 16,
  parameter int size           = 3,
  parameter int max_layer_size = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [data_size*size-1:0] dc_dw_stream,
  input  logic                      stream_valid,
  output logic                      stream_ready,
  input  logic [31:0]               layer_index,
  input  logic [data_size-1:0]      lr,
  input  logic                      weight_load,
  input  logic [31:0]               load_layer,
  input  logic [31:0]               load_row,
  input  logic [data_size*size-1:0] load_data,
  input  logic [31:0]               rd_layer,
  input  logic [31:0]               rd_row,
  output logic [data_size*size-1:0] rd_data,
  output logic                      update_done,
  output logic                      layer_err
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
  ,
  output logic                      clip_hit
`endif
);

  localparam int LW   = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
  localparam int RW   = (size > 1) ? $clog2(size) : 1;
  localparam int RowW = data_size * size;

  wu_state_e state_q, state_d;

  logic [max_layer_size-1:0][size-1:0][RowW-1:0] wbank_q;
  logic [size-1:0][RowW-1:0]                     grad_q;
  logic [RW-1:0]        row_cnt_q;
  logic [LW-1:0]        layer_q;
  logic                 layer_bad_q;
  logic [data_size-1:0] lr_q;
  logic [RowW-1:0]      rd_data_q;
  logic                 update_done_q;
  logic                 layer_err_q;

  logic            fire;
  logic            row_last;
  logic            layer_ok;
  logic            load_ok;
  logic            rd_ok;
  logic            load_we;
  logic            apply_we;
  logic [RowW-1:0] w_new;

  assign fire     = stream_valid && stream_ready;
  assign row_last = (row_cnt_q == RW'(size-1));
  assign layer_ok = (layer_index < 32'(max_layer_size));
  assign load_ok  = (load_layer < 32'(max_layer_size)) && (load_row < 32'(size));
  assign rd_ok    = (rd_layer < 32'(max_layer_size)) && (rd_row < 32'(size));

`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
  logic row_clip;
  logic clip_any_q;
  logic clip_hit_q;
`endif

  // One shared updater works on whichever row APPLY is currently writing.
  weight_row_updater #(
    .data_size (data_size),
    .size      (size)
  ) u_row_upd (
    .w_row_i (wbank_q[layer_q][row_cnt_q]),
    .g_row_i (grad_q[row_cnt_q]),
    .lr_i    (lr_q),
    .w_row_o (w_new)
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
    ,
    .clip_o  (row_clip)
`endif
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: collect size beats, spend size cycles applying, pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire) state_d = (size == 1) ? APPLY : ACCUM;
      ACCUM:   if (fire && row_last) state_d = APPLY;
      APPLY:   if (row_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: load wins over the stream in IDLE; invalid layers suppress writes.
  always_comb begin
    stream_ready = 1'b0;
    load_we      = 1'b0;
    apply_we     = 1'b0;
    case (state_q)
      IDLE: begin
        stream_ready = !weight_load;
        load_we      = weight_load && load_ok;
      end
      ACCUM:   stream_ready = 1'b1;
      APPLY:   apply_we     = !layer_bad_q;
      default: ;
    endcase
  end

  // Gradient capture and row counter; layer/lr are taken from the first beat only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grad_q      <= '0;
      row_cnt_q   <= '0;
      layer_q     <= '0;
      layer_bad_q <= 1'b0;
      lr_q        <= '0;
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
      clip_any_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (fire) begin
          grad_q[0]   <= dc_dw_stream;
          layer_bad_q <= !layer_ok;
          // Park a bad layer on slot 0 so the updater never reads out of range.
          layer_q     <= layer_ok ? layer_index[LW-1:0] : '0;
          lr_q        <= lr;
          row_cnt_q   <= (size == 1) ? '0 : RW'(1);
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
          clip_any_q  <= 1'b0;
`endif
        end
        ACCUM: if (fire) begin
          grad_q[row_cnt_q] <= dc_dw_stream;
          row_cnt_q         <= row_last ? '0 : row_cnt_q + 1'b1;
        end
        APPLY: begin
          row_cnt_q  <= row_last ? '0 : row_cnt_q + 1'b1;
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
          clip_any_q <= clip_any_q | row_clip;
`endif
        end
        default: ;
      endcase
    end
  end

  // Weight bank: load port in IDLE, SGD row write in APPLY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbank_q <= '0;
    end else if (load_we) begin
      wbank_q[load_layer[LW-1:0]][load_row[RW-1:0]] <= load_data;
    end else if (apply_we) begin
      wbank_q[layer_q][row_cnt_q] <= w_new;
    end
  end

  // Registered read port; a same-edge write shows up one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data_q <= '0;
    else if (rd_ok) rd_data_q <= wbank_q[rd_layer[LW-1:0]][rd_row[RW-1:0]];
    else            rd_data_q <= '0;
  end

  // Completion flags, registered out of the DONE state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      update_done_q <= 1'b0;
      layer_err_q   <= 1'b0;
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
      clip_hit_q    <= 1'b0;
`endif
    end else begin
      update_done_q <= (state_q == DONE);
      layer_err_q   <= (state_q == DONE) && layer_bad_q;
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
      clip_hit_q    <= (state_q == DONE) && clip_any_q;
`endif
    end
  end

  assign rd_data     = rd_data_q;
  assign update_done = update_done_q;
  assign layer_err   = layer_err_q;
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
  assign clip_hit    = clip_hit_q;
`endif

endmodule

// File: tb/tb_weight_update_stream.sv
// Directed bench for weight_update_stream (Q8.8, size=3, 10 layers).
module tb_weight_update_stream;
  localparam int DW = 16;
  localparam int N  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW*N-1:0] dc_dw_stream;
  logic          stream_valid;
  logic          stream_ready;
  logic [31:0]   layer_index;
  logic [DW-1:0] lr;
  logic          weight_load;
  logic [31:0]   load_layer;
  logic [31:0]   load_row;
  logic [DW*N-1:0] load_data;
  logic [31:0]   rd_layer;
  logic [31:0]   rd_row;
  logic [DW*N-1:0] rd_data;
  logic          update_done;
  logic          layer_err;
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
  logic          clip_hit;
`endif

  int total = 0;
  int bad   = 0;

  weight_update_stream dut (
    .clk          (clk),
    .reset        (reset),
    .dc_dw_stream (dc_dw_stream),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .layer_index  (layer_index),
    .lr           (lr),
    .weight_load  (weight_load),
    .load_layer   (load_layer),
    .load_row     (load_row),
    .load_data    (load_data),
    .rd_layer     (rd_layer),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .update_done  (update_done),
    .layer_err    (layer_err)
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
    ,
    .clip_hit     (clip_hit)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW*N-1:0] rep(input logic [DW-1:0] e);
    return {e, e, e};
  endfunction

  task automatic idle_in();
    stream_valid = 1'b0; dc_dw_stream = '0; layer_index = '0; lr = '0;
    weight_load = 1'b0; load_layer = '0; load_row = '0; load_data = '0;
    rd_layer = '0; rd_row = '0;
  endtask

  task automatic do_load(input int l, input int r, input logic [DW*N-1:0] d);
    @(negedge clk);
    weight_load = 1'b1; load_layer = l; load_row = r; load_data = d;
    @(negedge clk);
    weight_load = 1'b0;
  endtask

  task automatic load_all(input int l, input logic [DW*N-1:0] d);
    for (int r = 0; r < N; r++) do_load(l, r, d);
  endtask

  task automatic do_read(input int l, input int r, output logic [DW*N-1:0] d);
    @(negedge clk);
    rd_layer = l; rd_row = r;
    @(negedge clk);
    d = rd_data;
  endtask

  // Presents three beats; later beats carry junk layer/lr that must be ignored.
  // Returns with the last beat still driven, just before its accepting edge.
  task automatic send_stream(input logic [DW*N-1:0] r0, input logic [DW*N-1:0] r1,
                             input logic [DW*N-1:0] r2, input int l,
                             input logic [DW-1:0] lrv, input int gap);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == 1 && gap > 0) begin
        stream_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      stream_valid = 1'b1;
      dc_dw_stream = (i == 0) ? r0 : (i == 1) ? r1 : r2;
      layer_index  = (i == 0) ? l : 9;
      lr           = (i == 0) ? lrv : 16'h7FFF;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (update_done !== 1'b0) begin bad++; $display("FAIL reset_update_done got=%b exp=0", update_done); end
    total++; if (layer_err !== 1'b0) begin bad++; $display("FAIL reset_layer_err got=%b exp=0", layer_err); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (stream_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", stream_ready); end
    weight_load = 1'b1; load_layer = 12;
    #1;
    total++; if (stream_ready !== 1'b0) begin bad++; $display("FAIL idle_ready_load got=%b exp=0", stream_ready); end
    @(negedge clk);
    weight_load = 1'b0;
  endtask

  task automatic test_basic_update();
    logic [DW*N-1:0] d;
    int n;
    load_all(2, rep(16'h0100));
    send_stream(rep(16'h0080), rep(16'h0080), rep(16'h0080), 2, 16'h0080, 0);
    @(negedge clk);
    stream_valid = 1'b0;
    n = 0;
    while (update_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", n); end
    total++; if (layer_err !== 1'b0) begin bad++; $display("FAIL basic_layer_err got=%b exp=0", layer_err); end
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
    total++; if (clip_hit !== 1'b0) begin bad++; $display("FAIL basic_clip_hit got=%b exp=0", clip_hit); end
`endif
    @(negedge clk);
    total++; if (update_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", update_done); end
    for (int r = 0; r < N; r++) begin
      do_read(2, r, d);
      total++; if (d !== rep(16'h00C0)) begin bad++; $display("FAIL basic_row%0d got=%h exp=%h", r, d, rep(16'h00C0)); end
    end
    do_read(1, 0, d);
    total++; if (d !== '0) begin bad++; $display("FAIL basic_other_layer got=%h exp=0", d); end
  endtask

  task automatic test_saturation();
    logic [DW*N-1:0] d;
    int n;
    load_all(0, {16'h8000, 16'h7FFF, 16'h8000});
    send_stream({16'h0100, 16'hFF00, 16'h0100}, {16'h0100, 16'hFF00, 16'h0100},
                {16'h0100, 16'hFF00, 16'h0100}, 0, 16'h0100, 0);
    @(negedge clk);
    stream_valid = 1'b0;
    n = 0;
    while (update_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL sat_latency got=%0d exp=4", n); end
    for (int r = 0; r < N; r++) begin
      do_read(0, r, d);
      total++; if (d !== {16'h8000, 16'h7FFF, 16'h8000}) begin bad++; $display("FAIL sat_row%0d got=%h exp=80007fff8000", r, d); end
    end
  endtask

  // Mixed-sign row: w = {1.0, 2.0, -1.0}, lr = 0.5, distinct g per row.
  task automatic test_mixed(input int l, input int gap, input bit hold_in_apply);
    logic [DW*N-1:0] d;
    logic [DW*N-1:0] exp_row [N];
    int n;
    exp_row[0] = {16'h00C0, 16'h0220, 16'hFE80};
    exp_row[1] = {16'h0100, 16'h0180, 16'hFEC0};
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
    exp_row[2] = {16'h0080, 16'h01C0, 16'hFF80};
`else
    exp_row[2] = {16'h0000, 16'h01C0, 16'hFF80};
`endif
    load_all(l, {16'h0100, 16'h0200, 16'hFF00});
    send_stream({16'h0080, 16'hFFC0, 16'h0100}, {16'h0000, 16'h0100, 16'h0080},
                {16'h0200, 16'h0080, 16'hFF00}, l, 16'h0080, gap);
    @(negedge clk);
    n = 0;
    if (hold_in_apply) begin
      dc_dw_stream = 48'hDEAD_BEEF_CAFE;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin @(negedge clk); n++; end
        total++; if (stream_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_cyc%0d got=%b exp=0", k, stream_ready); end
      end
    end
    stream_valid = 1'b0;
    while (update_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL mixed_l%0d_latency got=%0d exp=4", l, n); end
    for (int r = 0; r < N; r++) begin
      do_read(l, r, d);
      total++; if (d !== exp_row[r]) begin bad++; $display("FAIL mixed_l%0d_row%0d got=%h exp=%h", l, r, d, exp_row[r]); end
    end
  endtask

  task automatic test_layer_err();
    logic [DW*N-1:0] d;
    int n;
    send_stream(rep(16'h0100), rep(16'h0100), rep(16'h0100), 10, 16'h0100, 0);
    @(negedge clk);
    stream_valid = 1'b0;
    n = 0;
    while (update_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL err_latency got=%0d exp=4", n); end
    total++; if (layer_err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", layer_err); end
    do_read(0, 0, d);
    total++; if (d !== {16'h8000, 16'h7FFF, 16'h8000}) begin bad++; $display("FAIL err_l0_unchanged got=%h", d); end
    do_read(2, 1, d);
    total++; if (d !== rep(16'h00C0)) begin bad++; $display("FAIL err_l2_unchanged got=%h exp=%h", d, rep(16'h00C0)); end
    do_read(10, 0, d);
    total++; if (d !== '0) begin bad++; $display("FAIL rd_bad_layer got=%h exp=0", d); end
    do_read(2, 3, d);
    total++; if (d !== '0) begin bad++; $display("FAIL rd_bad_row got=%h exp=0", d); end
    do_load(1, 5, rep(16'h1234));
    do_read(1, 1, d);
    total++; if (d !== '0) begin bad++; $display("FAIL load_bad_row got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid_apply();
    logic [DW*N-1:0] d;
    int n;
    bit seen;
    load_all(1, rep(16'h0100));
    do_read(1, 0, d);
    send_stream(rep(16'h0080), rep(16'h0080), rep(16'h0080), 1, 16'h0080, 0);
    @(negedge clk);
    stream_valid = 1'b0;
    @(negedge clk);
    // Row 0 was written on the previous edge; the read on that edge saw the old row.
    total++; if (rd_data !== rep(16'h0100)) begin bad++; $display("FAIL rd_old_on_write got=%h exp=%h", rd_data, rep(16'h0100)); end
    reset = 1'b0;
    #1;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL midrst_rd_data got=%h exp=0", rd_data); end
    total++; if (update_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", update_done); end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (update_done === 1'b1) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b exp=0", seen); end
    do_read(1, 0, d);
    total++; if (d !== '0) begin bad++; $display("FAIL midrst_row0_cleared got=%h exp=0", d); end
    load_all(1, rep(16'h0100));
    send_stream(rep(16'h0080), rep(16'h0080), rep(16'h0080), 1, 16'h0080, 0);
    @(negedge clk);
    stream_valid = 1'b0;
    n = 0;
    while (update_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL fresh_latency got=%0d exp=4", n); end
    for (int r = 0; r < N; r++) begin
      do_read(1, r, d);
      total++; if (d !== rep(16'h00C0)) begin bad++; $display("FAIL fresh_row%0d got=%h exp=%h", r, d, rep(16'h00C0)); end
    end
  endtask

`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
  task automatic test_clip();
    logic [DW*N-1:0] d;
    int n;
    load_all(5, rep(16'h0200));
    send_stream(rep(16'h0400), rep(16'h0400), rep(16'h0400), 5, 16'h0100, 0);
    @(negedge clk);
    stream_valid = 1'b0;
    n = 0;
    while (update_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL clip_latency got=%0d exp=4", n); end
    total++; if (clip_hit !== 1'b1) begin bad++; $display("FAIL clip_hit got=%b exp=1", clip_hit); end
    for (int r = 0; r < N; r++) begin
      do_read(5, r, d);
      total++; if (d !== rep(16'h0100)) begin bad++; $display("FAIL clip_row%0d got=%h exp=%h", r, d, rep(16'h0100)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_update();
    test_saturation();
    test_mixed(3, 0, 1'b0);
    test_mixed(4, 4, 1'b1);
    test_layer_err();
    test_reset_mid_apply();
`ifdef WEIGHT_UPDATE_GRAD_CLIP_EN
    test_clip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
